// File: rtl/debounce_bank.sv
// Multi-channel push-button debouncer: 2-flop sync, symmetric stability qualification,
// rise/fall strobes and long-press strobe. Define DEBOUNCE_BANK_HOLD_REPEAT_EN for hold auto-repeat.
module debounce_bank #(
    parameter int CH         = 4,
    parameter int CNT_W      = 16,
    parameter int STABLE_CYC = 16,
    parameter int HOLD_CYC   = 1000,
    parameter int REPEAT_CYC = 250
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CH-1:0] noisy,
    output logic [CH-1:0] level,
    output logic [CH-1:0] rise,
    output logic [CH-1:0] fall,
    output logic [CH-1:0] hold
);

    localparam longint CNT_LIM = 64'd1 << CNT_W;

    // Bad parameter sets would silently wrap the counters, so refuse to elaborate them.
    if (CH < 1 || STABLE_CYC < 1 || HOLD_CYC < 1 || REPEAT_CYC < 1 ||
        STABLE_CYC >= CNT_LIM || HOLD_CYC >= CNT_LIM || REPEAT_CYC >= CNT_LIM) begin : g_bad_params
        $error("debounce_bank: parameter out of range");
    end

    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_TOP    = CNT_W'(HOLD_CYC);
    localparam logic [CNT_W-1:0] HOLD_PRE    = CNT_W'(HOLD_CYC - 1);

    logic [CH-1:0]    s1, s2;
    logic [CNT_W-1:0] cnt      [CH];
    logic [CNT_W-1:0] cnt_nxt  [CH];
    logic [CNT_W-1:0] hcnt     [CH];
    logic [CNT_W-1:0] hcnt_nxt [CH];
    logic [CH-1:0]    level_nxt, rise_nxt, fall_nxt, hold_nxt;

`ifdef DEBOUNCE_BANK_HOLD_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_PRE = CNT_W'(REPEAT_CYC - 1);
    logic [CNT_W-1:0] rcnt     [CH];
    logic [CNT_W-1:0] rcnt_nxt [CH];
`endif

    always_comb begin
        for (int i = 0; i < CH; i++) begin
            // NOTE: every output of this block gets a default first, so no path can infer a latch.
            level_nxt[i] = level[i];
            rise_nxt[i]  = 1'b0;
            fall_nxt[i]  = 1'b0;
            hold_nxt[i]  = 1'b0;
            cnt_nxt[i]   = '0;
            hcnt_nxt[i]  = '0;
`ifdef DEBOUNCE_BANK_HOLD_REPEAT_EN
            rcnt_nxt[i]  = '0;
`endif
            // Any cycle where s2 agrees with level leaves cnt at 0 and restarts qualification.
            if (s2[i] != level[i]) begin
                if (cnt[i] == STABLE_LAST) begin
                    level_nxt[i] = s2[i];
                    rise_nxt[i]  = s2[i];
                    fall_nxt[i]  = ~s2[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + CNT_ONE;
                end
            end

            // A release on this edge clears the hold counters and suppresses any strobe.
            if (level[i] && level_nxt[i]) begin
                if (hcnt[i] != HOLD_TOP) begin
                    hcnt_nxt[i] = hcnt[i] + CNT_ONE;
                    hold_nxt[i] = (hcnt[i] == HOLD_PRE);
                end else begin
                    hcnt_nxt[i] = hcnt[i];
`ifdef DEBOUNCE_BANK_HOLD_REPEAT_EN
                    if (rcnt[i] == REP_PRE) begin
                        hold_nxt[i] = 1'b1;
                    end else begin
                        rcnt_nxt[i] = rcnt[i] + CNT_ONE;
                    end
`endif
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= '0;
            s2    <= '0;
            level <= '0;
            rise  <= '0;
            fall  <= '0;
            hold  <= '0;
            // NOTE: the counters are per-channel flops, not a RAM, so they are cleared with the rest.
            cnt   <= '{default: '0};
            hcnt  <= '{default: '0};
`ifdef DEBOUNCE_BANK_HOLD_REPEAT_EN
            rcnt  <= '{default: '0};
`endif
        end else begin
            // NOTE: non-blocking so s2 takes the old s1, giving a true two-flop chain.
            s1    <= noisy;
            s2    <= s1;
            level <= level_nxt;
            rise  <= rise_nxt;
            fall  <= fall_nxt;
            hold  <= hold_nxt;
            cnt   <= cnt_nxt;
            hcnt  <= hcnt_nxt;
`ifdef DEBOUNCE_BANK_HOLD_REPEAT_EN
            rcnt  <= rcnt_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_debounce_bank.sv
// Scoreboard bench for debounce_bank: expected strobe events are queued when stimulus
// is driven and checked every cycle, with the expected level derived from those events.
module tb_debounce_bank;

    localparam int STABLE = 4;
    localparam int LAT    = STABLE + 2;   // drive at negedge k -> level changes at edge k+LAT
    localparam int HOLD   = 20;
    localparam int REPEAT = 8;

    typedef enum logic [1:0] {EV_RISE, EV_FALL, EV_HOLD} ev_kind_e;
    typedef struct {
        int       at;
        int       ch;
        ev_kind_e kind;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] noisy;
    logic [3:0] level, rise, fall, hold;

    logic [3:0] exp_level, exp_rise, exp_fall, exp_hold;
    ev_t        sb[$];
    int         cyc = 0;
    int         compared = 0;
    int         mismatched = 0;

    debounce_bank #(
        .CH(4), .CNT_W(8), .STABLE_CYC(STABLE), .HOLD_CYC(HOLD), .REPEAT_CYC(REPEAT)
    ) dut (
        .clk(clk), .rst(rst), .noisy(noisy),
        .level(level), .rise(rise), .fall(fall), .hold(hold)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d required < 20000", cyc);
        $fatal(1);
    end

    task automatic push_ev(input int at, input int ch, input ev_kind_e kind);
        sb.push_back('{at, ch, kind});
    endtask

    // Collects the events due at the current edge and advances the expected level.
    task automatic build_exp();
        exp_rise = '0;
        exp_fall = '0;
        exp_hold = '0;
        for (int j = sb.size() - 1; j >= 0; j--) begin
            if (sb[j].at == cyc) begin
                case (sb[j].kind)
                    EV_RISE: exp_rise[sb[j].ch] = 1'b1;
                    EV_FALL: exp_fall[sb[j].ch] = 1'b1;
                    default: exp_hold[sb[j].ch] = 1'b1;
                endcase
                sb.delete(j);
            end
        end
        exp_level = (exp_level | exp_rise) & ~exp_fall;
    endtask

    task automatic test_reset();
        int base;
        rst   = 1'b1;
        noisy = 4'hF;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            exp_level = '0;
            sb.delete();
            compared++;
            if ({level, rise, fall, hold} !== 16'h0000) begin
                mismatched++;
                $display("FAIL reset_hold cyc=%0d got level=%h rise=%h fall=%h hold=%h required all 0",
                         cyc, level, rise, fall, hold);
            end
        end
        base = cyc;
        rst  = 1'b0;
        for (int c = 0; c < 4; c++) push_ev(base + LAT, c, EV_RISE);
        for (int t = 0; t < 20; t++) begin
            if (t == 8) begin
                noisy = 4'h0;
                for (int c = 0; c < 4; c++) push_ev(cyc + LAT, c, EV_FALL);
            end
            @(negedge clk);
            build_exp();
            compared++;
            if ({level, rise, fall, hold} !== {exp_level, exp_rise, exp_fall, exp_hold}) begin
                mismatched++;
                $display("FAIL reset_release cyc=%0d got l/r/f/h=%h/%h/%h/%h required %h/%h/%h/%h",
                         cyc, level, rise, fall, hold, exp_level, exp_rise, exp_fall, exp_hold);
            end
        end
    endtask

    task automatic test_glitch();
        int base;
        for (int len = STABLE - 1; len <= STABLE; len++) begin
            base = cyc;
            if (len >= STABLE) begin
                push_ev(base + LAT, 0, EV_RISE);
                push_ev(base + len + LAT, 0, EV_FALL);
            end
            for (int t = 0; t < 16; t++) begin
                noisy = (t < len) ? 4'b0001 : 4'b0000;
                @(negedge clk);
                build_exp();
                compared++;
                if ({level, rise, fall, hold} !== {exp_level, exp_rise, exp_fall, exp_hold}) begin
                    mismatched++;
                    $display("FAIL glitch_len%0d cyc=%0d got l/r/f/h=%h/%h/%h/%h required %h/%h/%h/%h",
                             len, cyc, level, rise, fall, hold, exp_level, exp_rise, exp_fall, exp_hold);
                end
            end
        end
    endtask

    task automatic test_toggle();
        int base;
        base = cyc;
        for (int t = 0; t < 64; t++) begin
            if (t < 40) noisy = ((t / 2) % 2 == 0) ? 4'b0010 : 4'b0000;
            else if (t < 50) noisy = 4'b0010;
            else noisy = 4'b0000;
            if (t == 40) push_ev(cyc + LAT, 1, EV_RISE);
            if (t == 50) push_ev(cyc + LAT, 1, EV_FALL);
            @(negedge clk);
            build_exp();
            compared++;
            if ({level, rise, fall, hold} !== {exp_level, exp_rise, exp_fall, exp_hold}) begin
                mismatched++;
                $display("FAIL toggle cyc=%0d t=%0d got l/r/f/h=%h/%h/%h/%h required %h/%h/%h/%h",
                         cyc, cyc - base, level, rise, fall, hold, exp_level, exp_rise, exp_fall, exp_hold);
            end
        end
    endtask

    task automatic test_hold();
        int base;
        base = cyc;
        push_ev(base + LAT, 2, EV_RISE);
        push_ev(base + LAT + HOLD, 2, EV_HOLD);
`ifdef DEBOUNCE_BANK_HOLD_REPEAT_EN
        push_ev(base + LAT + HOLD + REPEAT, 2, EV_HOLD);
        push_ev(base + LAT + HOLD + 2 * REPEAT, 2, EV_HOLD);
`endif
        for (int t = 0; t < 56; t++) begin
            noisy = (t < 40) ? 4'b0100 : 4'b0000;
            if (t == 40) push_ev(cyc + LAT, 2, EV_FALL);
            @(negedge clk);
            build_exp();
            compared++;
            if ({level, rise, fall, hold} !== {exp_level, exp_rise, exp_fall, exp_hold}) begin
                mismatched++;
                $display("FAIL hold cyc=%0d t=%0d got l/r/f/h=%h/%h/%h/%h required %h/%h/%h/%h",
                         cyc, cyc - base, level, rise, fall, hold, exp_level, exp_rise, exp_fall, exp_hold);
            end
        end
    endtask

    task automatic test_release_simul();
        int base;
        base = cyc;
        push_ev(base + LAT, 3, EV_RISE);
        for (int t = 0; t < 36; t++) begin
            if (t < 16) noisy = 4'b1000;
            else if (t < 24) noisy = 4'b0001;
            else noisy = 4'b0000;
            if (t == 16) begin
                push_ev(cyc + LAT, 3, EV_FALL);
                push_ev(cyc + LAT, 0, EV_RISE);
            end
            if (t == 24) push_ev(cyc + LAT, 0, EV_FALL);
            @(negedge clk);
            build_exp();
            compared++;
            if ({level, rise, fall, hold} !== {exp_level, exp_rise, exp_fall, exp_hold}) begin
                mismatched++;
                $display("FAIL release_simul cyc=%0d t=%0d got l/r/f/h=%h/%h/%h/%h required %h/%h/%h/%h",
                         cyc, cyc - base, level, rise, fall, hold, exp_level, exp_rise, exp_fall, exp_hold);
            end
        end
    endtask

    task automatic test_reset_mid();
        int base;
        base = cyc;
        for (int t = 0; t < 26; t++) begin
            noisy = (t < 14) ? 4'b0001 : 4'b0000;
            rst   = (t == 4);
            if (t == 5) push_ev(cyc + LAT, 0, EV_RISE);
            if (t == 14) push_ev(cyc + LAT, 0, EV_FALL);
            @(negedge clk);
            if (t == 4) exp_level = '0;
            build_exp();
            compared++;
            if ({level, rise, fall, hold} !== {exp_level, exp_rise, exp_fall, exp_hold}) begin
                mismatched++;
                $display("FAIL reset_mid cyc=%0d t=%0d got l/r/f/h=%h/%h/%h/%h required %h/%h/%h/%h",
                         cyc, cyc - base, level, rise, fall, hold, exp_level, exp_rise, exp_fall, exp_hold);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        noisy     = 4'h0;
        exp_level = '0;
        test_reset();
        test_glitch();
        test_toggle();
        test_hold();
        test_release_simul();
        test_reset_mid();
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL leftover_events got %0d unconsumed required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
